// File: rtl/wb_mem_responder.sv
// Wishbone classic responder backed by a word-addressed RAM with programmable
// response latency and a post-ack gap during which new strobes are ignored.
module wb_mem_responder #(
  parameter int    MEM_WORDS   = 4096,
  parameter int    LATENCY     = 1,
  parameter int    ACK_GAP     = 1,
  parameter string MEMORY_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        err_o
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [1:0]    gcnt_q, gcnt_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          in_range_q, in_range_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          mem_we;
  logic          req_in_range;
  logic          unused_addr_lsb;

  logic [31:0] mem [MEM_WORDS];

  assign unused_addr_lsb = ^addr_i[1:0];
  assign req_in_range    = (addr_i[31:2] < 30'(MEM_WORDS));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gcnt_d     = gcnt_q;
    we_d       = we_q;
    sel_d      = sel_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    in_range_d = in_range_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rdata_d    = 32'h0;
    mem_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cyc_i && stb_i) begin
          we_d       = we_i;
          sel_d      = sel_i;
          idx_d      = addr_i[AW+1:2];
          wdata_d    = data_i;
          in_range_d = req_in_range;
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 3'(LATENCY - 2);
          end
        end
      end
      S_WAIT: begin
        if (!cyc_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == 3'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        // The registered ack/err appears in the cycle after this one; an
        // abort here simply never sets them and never commits the write.
        if (!cyc_i) begin
          state_d = S_IDLE;
        end else begin
          ack_d = in_range_q;
          err_d = !in_range_q;
          if (in_range_q && we_q) begin
            mem_we = !rst;
          end else if (in_range_q) begin
            rdata_d = mem[idx_q];
          end
          if (ACK_GAP == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
            gcnt_d  = 2'(ACK_GAP - 1);
          end
        end
      end
      S_GAP: begin
        if (gcnt_q == 2'd0) begin
          state_d = S_IDLE;
        end else begin
          gcnt_d = gcnt_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      gcnt_q     <= 2'd0;
      we_q       <= 1'b0;
      sel_q      <= 4'h0;
      idx_q      <= '0;
      wdata_q    <= 32'h0;
      in_range_q <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gcnt_q     <= gcnt_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      in_range_q <= in_range_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  // RAM has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && sel_q[b]) begin
        mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign ack_o  = ack_q;
  assign err_o  = err_q;
  assign data_o = rdata_q;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: three instances with different latency, gap and
// depth, checked against a word-level memory model with randomized traffic.
module tb_wb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst;
  logic [2:0]  cyc;
  logic [2:0]  stb;
  logic [2:0]  we;
  logic [2:0]  ack;
  logic [2:0]  err;
  logic [3:0]  sel   [3];
  logic [31:0] addr  [3];
  logic [31:0] wdat  [3];
  logic [31:0] rdat  [3];

  int lat_c   [3] = '{1, 4, 3};
  int gap_c   [3] = '{1, 2, 0};
  int words_c [3] = '{4096, 1024, 1024};

  wb_mem_responder #(.MEM_WORDS(4096), .LATENCY(1), .ACK_GAP(1)) dut_a (
    .clk(clk), .rst(rst[0]), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]),
    .sel_i(sel[0]), .addr_i(addr[0]), .data_i(wdat[0]), .data_o(rdat[0]),
    .ack_o(ack[0]), .err_o(err[0]));

  wb_mem_responder #(.MEM_WORDS(1024), .LATENCY(4), .ACK_GAP(2)) dut_b (
    .clk(clk), .rst(rst[1]), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]),
    .sel_i(sel[1]), .addr_i(addr[1]), .data_i(wdat[1]), .data_o(rdat[1]),
    .ack_o(ack[1]), .err_o(err[1]));

  wb_mem_responder #(.MEM_WORDS(1024), .LATENCY(3), .ACK_GAP(0)) dut_c (
    .clk(clk), .rst(rst[2]), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we[2]),
    .sel_i(sel[2]), .addr_i(addr[2]), .data_i(wdat[2]), .data_o(rdat[2]),
    .ack_o(ack[2]), .err_o(err[2]));

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_mem [int];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int mkey(input int k, input logic [31:0] a);
    return k * 65536 + int'(a[13:2]);
  endfunction

  function automatic bit in_range(input int k, input logic [31:0] a);
    return ({2'b00, a[31:2]} < 32'(words_c[k]));
  endfunction

  // One complete transaction; fields are scrambled right after acceptance.
  task automatic txn(input int k, input bit w, input logic [3:0] s,
                     input logic [31:0] a, input logic [31:0] d);
    bit          inr;
    logic [31:0] exp_d;
    logic [31:0] word;
    int          kk;
    inr   = in_range(k, a);
    exp_d = 32'h0;
    if (inr) begin
      kk   = mkey(k, a);
      word = model_mem.exists(kk) ? model_mem[kk] : 32'h0;
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) word[8*b +: 8] = d[8*b +: 8];
        model_mem[kk] = word;
      end else begin
        exp_d = word;
      end
    end
    @(negedge clk);
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; sel[k] = s; addr[k] = a; wdat[k] = d;
    @(posedge clk);
    @(negedge clk);
    stb[k] = 1'b0; we[k] = 1'($urandom); sel[k] = 4'($urandom);
    addr[k] = $urandom; wdat[k] = $urandom;
    for (int c = 1; c <= lat_c[k]; c++) begin
      @(negedge clk);
      if (c < lat_c[k]) begin
        chk($sformatf("early_resp_d%0d_c%0d", k, c), {30'b0, ack[k], err[k]}, 32'h0);
      end else begin
        chk($sformatf("ack_d%0d_a%h", k, a), {31'b0, ack[k]}, {31'b0, inr});
        chk($sformatf("err_d%0d_a%h", k, a), {31'b0, err[k]}, {31'b0, !inr});
        chk($sformatf("data_d%0d_a%h", k, a), rdat[k], exp_d);
      end
    end
    cyc[k] = 1'b0;
    repeat (gap_c[k]) @(negedge clk);
  endtask

  initial begin
    logic [31:0] exp_w;
    logic [29:0] idx;
    int          r;
    rst = 3'b111; cyc = 3'b0; stb = 3'b0; we = 3'b0;
    for (int k = 0; k < 3; k++) begin
      sel[k] = 4'h0; addr[k] = 32'h0; wdat[k] = 32'h0;
    end
    repeat (3) @(negedge clk);
    rst = 3'b000;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_ack_d%0d", k), {31'b0, ack[k]}, 32'h0);
      chk($sformatf("reset_err_d%0d", k), {31'b0, err[k]}, 32'h0);
      chk($sformatf("reset_data_d%0d", k), rdat[k], 32'h0);
    end

    // Give every word the model tracks a known value, including the last word.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) txn(k, 1'b1, 4'hF, 32'(i) << 2, $urandom);
      txn(k, 1'b1, 4'hF, 32'(words_c[k] - 1) << 2, $urandom);
    end

    // Byte-lane writes on the single-cycle instance.
    txn(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    txn(0, 1'b0, 4'hF, 32'h10, 32'h0);
    txn(0, 1'b1, 4'h1, 32'h10, 32'h000000AA);
    txn(0, 1'b0, 4'hF, 32'h10, 32'h0);
    txn(0, 1'b1, 4'h0, 32'h10, 32'h12345678);
    txn(0, 1'b0, 4'hF, 32'h10, 32'h0);
    txn(0, 1'b0, 4'hF, 32'h0000_4000, 32'h0);

    // Out-of-range accesses on a 1024-word instance; word 0 must survive.
    txn(1, 1'b1, 4'hF, 32'h0, 32'h0BADF00D);
    txn(1, 1'b0, 4'hF, 32'h1000, 32'h0);
    txn(1, 1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF);
    txn(1, 1'b0, 4'hF, 32'h0, 32'h0);
    txn(1, 1'b0, 4'hF, 32'h0FFC, 32'h0);

    // Strobe held through the gap: exactly two acks, at 4 and 4+2+1+4 cycles.
    exp_w = model_mem[mkey(1, 32'h0)];
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; sel[1] = 4'hF; addr[1] = 32'h0;
    @(posedge clk);
    @(negedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_ack_c%0d", c), {31'b0, ack[1]}, {31'b0, (c == 4 || c == 11)});
      chk($sformatf("b2b_err_c%0d", c), {31'b0, err[1]}, 32'h0);
      if (c == 4 || c == 11) chk($sformatf("b2b_data_c%0d", c), rdat[1], exp_w);
      if (c == 11) begin
        stb[1] = 1'b0; cyc[1] = 1'b0;
      end
    end
    repeat (gap_c[1]) @(negedge clk);

    // Abort in WAIT: no response, no write, and the next request runs normally.
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 4'hF;
    addr[2] = 32'h20; wdat[2] = ~model_mem[mkey(2, 32'h20)];
    @(posedge clk);
    @(negedge clk);
    cyc[2] = 1'b0; stb[2] = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("abort_resp_c%0d", c), {30'b0, ack[2], err[2]}, 32'h0);
    end
    txn(2, 1'b0, 4'hF, 32'h20, 32'h0);

    // Reset while waiting: response suppressed, RAM contents kept.
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; sel[1] = 4'hF; addr[1] = 32'h0;
    @(posedge clk);
    @(negedge clk);
    stb[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    chk("rst_wait_data", rdat[1], 32'h0);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("rst_wait_resp_c%0d", c), {30'b0, ack[1], err[1]}, 32'h0);
      @(negedge clk);
    end
    cyc[1] = 1'b0;
    txn(1, 1'b0, 4'hF, 32'h0, 32'h0);
    txn(1, 1'b0, 4'hF, 32'h3C, 32'h0);

    // Randomized traffic over tracked words plus out-of-range addresses.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 40; n++) begin
        r = $urandom_range(0, 9);
        if (r < 7)       idx = 30'($urandom_range(0, 15));
        else if (r == 7) idx = 30'(words_c[k] - 1);
        else if (r == 8) idx = 30'(words_c[k] + $urandom_range(0, 300));
        else             idx = 30'h3FFFFFFF;
        txn(k, 1'($urandom), 4'($urandom), {idx, 2'($urandom)}, $urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
